pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit; successor to the fixed 8-bit PC incrementer. Holds the PC register and computes the next PC for increment, relative branch, absolute jump, call and return. Includes an internal return-address stack for call/return. Sits between control FSM and instruction memory address port in the multicycle datapath.

Parameters:
WIDTH, 8, PC/address width in bits
STEP, 1, increment added for sequential fetch (modulo 2^WIDTH)
DEPTH, 4, return-address stack entries (power of 2, >=2)
RESET_VEC, 0, PC value after reset
TRAP_VEC, 8'hFF truncated/extended to WIDTH, trap target (used only with PC_TRAP_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  PC write enable; 0 = all state held, op ignored
op  in  3  000 hold, 001 inc, 010 branch-rel, 011 jump-abs, 100 call, 101 ret, 11x hold
offset  in  WIDTH  signed two's-complement branch offset
target  in  WIDTH  absolute jump/call target
pc_out  out  WIDTH  current PC (registered)
pc_seq  out  WIDTH  combinational pc_out + STEP (mod 2^WIDTH)
stack_full  out  1  stack holds DEPTH entries
stack_empty  out  1  stack holds 0 entries
err  out  1  sticky error: overflow push or underflow pop since reset

Behaviour:
- Reset (reset=0, async): pc_out=RESET_VEC, sp=0, stack entries=0, err=0; stack_empty=1, stack_full=0.
- All updates on rising clock edge when en=1; latency 1 cycle, new PC visible on pc_out next cycle.
- inc: pc <= pc+STEP. branch-rel: pc <= pc+offset (relative to current pc, sign-extended, wraps mod 2^WIDTH). jump-abs: pc <= target. hold/11x: no change.
- call: push pc+STEP, pc <= target, sp <= sp+1.
- ret: pc <= top entry, sp <= sp-1.
- Call when full: push suppressed (sp and contents unchanged), pc <= target, err <= 1.
- Ret when empty: sp unchanged, pc <= pc+STEP, err <= 1.
- err clears only on reset.
- en=0 with any op: pc, sp, stack, err unchanged.
- pc_seq, stack_full and stack_empty are derived combinationally from registered state.
- Reset asserted mid-operation overrides any pending update.
- Arithmetic: all additions WIDTH bits, carry discarded; 0xFF+1 -> 0x00 at WIDTH=8.

Optional Feature:
PC_TRAP_EN. Defined: call-when-full and ret-when-empty set pc <= TRAP_VEC instead of the default target, and set err. Stack is unchanged. Undefined: default behaviour above; TRAP_VEC unused.

Decomposition:
- Package pc_unit_pkg: op encoding constants (PC_OP_HOLD, PC_OP_INC, PC_OP_BREL, PC_OP_JABS, PC_OP_CALL, PC_OP_RET).
- One sub-module pc_ret_stack: DEPTH x WIDTH LIFO with push/pop, full/empty, async active-low reset.
- Next-PC mux and err logic stay in pc_unit.

Test Plan:
- Reset then 3 cycles of inc (WIDTH=8, STEP=1) -> pc_out 0x00,0x01,0x02,0x03; at pc=0xFF inc -> 0x00.
- pc=0x10, branch-rel offset=0xFC -> 0x0C; offset=0x05 -> 0x11 (from 0x0C); en=0 with op=inc -> pc unchanged.
- pc=0x20, call target=0x80 -> pc 0x80, stack_empty=0; ret -> pc 0x21, stack_empty=1, err=0.
- 4 calls fill stack (stack_full=1), 5th call target=0x40 -> pc 0x40, err=1. 4 rets return in LIFO order; next ret -> pc+1, err stays 1.
- ret on empty stack after reset -> pc 0x01, err=1. With PC_TRAP_EN defined, same case -> pc TRAP_VEC (0xFF).
- Reset asserted asynchronously mid-cycle during a call -> pc_out=RESET_VEC immediately, sp=0, err=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_pkg
// Purpose  : Operation encodings shared by the program-counter unit and its
//            users (control FSM, testbenches).
// Revision : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

   localparam logic [2:0] PC_OP_HOLD = 3'b000;
   localparam logic [2:0] PC_OP_INC  = 3'b001;
   localparam logic [2:0] PC_OP_BREL = 3'b010;
   localparam logic [2:0] PC_OP_JABS = 3'b011;
   localparam logic [2:0] PC_OP_CALL = 3'b100;
   localparam logic [2:0] PC_OP_RET  = 3'b101;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_ret_stack
// Purpose  : DEPTH x WIDTH LIFO holding return addresses. Push on a full
//            stack and pop on an empty stack are ignored; push wins if both
//            are requested together. Asynchronous active-low reset clears
//            the pointer and every entry.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ret_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_top,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_PW = $clog2(DEPTH);

   // Pointer has one spare bit so that "DEPTH entries" is distinct from 0.
   logic [c_PW:0]      r_sp;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PW-1:0]    w_wr_idx;
   logic [c_PW-1:0]    w_top_idx;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_sp == (c_PW+1)'(DEPTH));
   assign o_empty   = (r_sp == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty & ~i_push;
   assign w_wr_idx  = r_sp[c_PW-1:0];
   // Wraps to DEPTH-1 when the pointer sits at DEPTH (full).
   assign w_top_idx = r_sp[c_PW-1:0] - c_PW'(1);
   assign o_top     = r_mem[w_top_idx];

   // Stack pointer and storage update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_push) begin
         r_mem[w_wr_idx] <= i_data;
         r_sp            <= r_sp + (c_PW+1)'(1);
      end else if (w_do_pop) begin
         r_sp <= r_sp - (c_PW+1)'(1);
      end
   end

endmodule : pc_ret_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Parametrised program counter with increment, relative branch,
//            absolute jump, call and return through an internal
//            return-address stack. Sticky err flags stack overflow/underflow.
// Options  : PC_TRAP_EN - when defined, call-when-full and ret-when-empty
//            redirect the PC to TRAP_VEC.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int STEP      = 1,
   parameter int DEPTH     = 4,
   parameter int RESET_VEC = 0,
   parameter int TRAP_VEC  = 'hFF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] offset,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_seq,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             err
);

   localparam logic [WIDTH-1:0] c_STEP      = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] c_RESET_VEC = WIDTH'(RESET_VEC);
   localparam logic [WIDTH-1:0] c_TRAP_VEC  = WIDTH'(TRAP_VEC);
`ifdef PC_TRAP_EN
   localparam logic             c_TRAP_EN   = 1'b1;
`else
   localparam logic             c_TRAP_EN   = 1'b0;
`endif

   logic [WIDTH-1:0] r_pc;
   logic             r_err;
   logic [WIDTH-1:0] w_next_pc;
   logic [WIDTH-1:0] w_top;
   logic             w_push;
   logic             w_pop;
   logic             w_set_err;
   logic             w_full;
   logic             w_empty;

   assign pc_out      = r_pc;
   assign pc_seq      = r_pc + c_STEP;
   assign stack_full  = w_full;
   assign stack_empty = w_empty;
   assign err         = r_err;

   pc_ret_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk     (clock),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (pc_seq),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-PC selection, stack requests and error detection.
   always_comb begin
      w_next_pc = r_pc;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_set_err = 1'b0;
      if (en) begin
         case (op)
            PC_OP_HOLD: w_next_pc = r_pc;
            PC_OP_INC:  w_next_pc = pc_seq;
            PC_OP_BREL: w_next_pc = r_pc + offset;
            PC_OP_JABS: w_next_pc = target;
            PC_OP_CALL: begin
               if (w_full) begin
                  w_set_err = 1'b1;
                  w_next_pc = c_TRAP_EN ? c_TRAP_VEC : target;
               end else begin
                  w_push    = 1'b1;
                  w_next_pc = target;
               end
            end
            PC_OP_RET: begin
               if (w_empty) begin
                  w_set_err = 1'b1;
                  w_next_pc = c_TRAP_EN ? c_TRAP_VEC : pc_seq;
               end else begin
                  w_pop     = 1'b1;
                  w_next_pc = w_top;
               end
            end
            default: w_next_pc = r_pc;
         endcase
      end
   end

   // PC register; w_next_pc already equals r_pc when disabled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc <= c_RESET_VEC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_set_err) begin
         r_err <= 1'b1;
      end
   end

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Directed scoreboard bench for pc_unit at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;
   import pc_unit_pkg::*;

`ifdef PC_TRAP_EN
   localparam logic [7:0] OVF_CALL_PC  = 8'hFF;
   localparam logic [7:0] UNF_RET_PC_A = 8'hFF;
   localparam logic [7:0] UNF_RET_PC_B = 8'hFF;
`else
   localparam logic [7:0] OVF_CALL_PC  = 8'h40;
   localparam logic [7:0] UNF_RET_PC_A = 8'h23;
   localparam logic [7:0] UNF_RET_PC_B = 8'h01;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       en    = 1'b0;
   logic [2:0] op    = 3'b000;
   logic [7:0] offset = 8'h00;
   logic [7:0] target = 8'h00;
   logic [7:0] pc_out;
   logic [7:0] pc_seq;
   logic       stack_full;
   logic       stack_empty;
   logic       err;

   pc_unit dut (
      .clock       (clock),
      .reset       (reset),
      .en          (en),
      .op          (op),
      .offset      (offset),
      .target      (target),
      .pc_out      (pc_out),
      .pc_seq      (pc_seq),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .err         (err)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc++;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  pc;
      logic        empty;
      logic        full;
      logic        err;
      string       name;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   function automatic logic [18:0] pack(logic [7:0] p, logic e, logic f, logic r);
      logic [7:0] s;
      s = p + 8'd1;
      return {p, s, e, f, r};
   endfunction

   task automatic chk(string nm, logic [18:0] act, logic [18:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got pc=%02h seq=%02h empty/full/err=%b, want pc=%02h seq=%02h empty/full/err=%b",
                  nm, act[18:11], act[10:3], act[2:0], expv[18:11], expv[10:3], expv[2:0]);
      end
   endtask

   // Monitor: compare the registered outputs against queued expectations.
   always @(negedge clock) begin
      exp_t x;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         x = q.pop_front();
         chk(x.name, {pc_out, pc_seq, stack_empty, stack_full, err},
             pack(x.pc, x.empty, x.full, x.err));
      end
   end

   // Drive one operation; its result is due after the next rising edge.
   task automatic apply(logic e, logic [2:0] o, logic [7:0] off, logic [7:0] tgt,
                        logic [7:0] xpc, logic xe, logic xf, logic xr, string nm);
      exp_t x;
      @(posedge clock);
      #1;
      en     = e;
      op     = o;
      offset = off;
      target = tgt;
      x.cyc   = cyc + 1;
      x.pc    = xpc;
      x.empty = xe;
      x.full  = xf;
      x.err   = xr;
      x.name  = nm;
      q.push_back(x);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, queue=%0d want 0", q.size());
      $fatal(1);
   end

   initial begin
      #12;
      chk("reset_state", {pc_out, pc_seq, stack_empty, stack_full, err}, pack(8'h00, 1, 0, 0));
      reset = 1'b1;

      apply(1, PC_OP_INC,  8'h00, 8'h00, 8'h01, 1, 0, 0, "inc1");
      apply(1, PC_OP_INC,  8'h00, 8'h00, 8'h02, 1, 0, 0, "inc2");
      apply(1, PC_OP_INC,  8'h00, 8'h00, 8'h03, 1, 0, 0, "inc3");
      apply(1, PC_OP_JABS, 8'h00, 8'hFF, 8'hFF, 1, 0, 0, "jabs_ff");
      apply(1, PC_OP_INC,  8'h00, 8'h00, 8'h00, 1, 0, 0, "inc_wrap");
      apply(1, PC_OP_JABS, 8'h00, 8'h10, 8'h10, 1, 0, 0, "jabs_10");
      apply(1, PC_OP_BREL, 8'hFC, 8'h00, 8'h0C, 1, 0, 0, "brel_neg");
      apply(1, PC_OP_BREL, 8'h05, 8'h00, 8'h11, 1, 0, 0, "brel_pos");
      apply(0, PC_OP_INC,  8'h00, 8'h00, 8'h11, 1, 0, 0, "en0_inc");
      apply(0, PC_OP_CALL, 8'h00, 8'h99, 8'h11, 1, 0, 0, "en0_call");
      apply(1, 3'b110,     8'h00, 8'h77, 8'h11, 1, 0, 0, "op110_hold");
      apply(1, 3'b111,     8'h00, 8'h77, 8'h11, 1, 0, 0, "op111_hold");
      apply(1, PC_OP_HOLD, 8'h00, 8'h77, 8'h11, 1, 0, 0, "op_hold");
      apply(1, PC_OP_JABS, 8'h00, 8'h20, 8'h20, 1, 0, 0, "jabs_20");
      apply(1, PC_OP_CALL, 8'h00, 8'h80, 8'h80, 0, 0, 0, "call_80");
      apply(1, PC_OP_RET,  8'h00, 8'h00, 8'h21, 1, 0, 0, "ret_21");
      apply(1, PC_OP_CALL, 8'h00, 8'hA0, 8'hA0, 0, 0, 0, "call_a0");
      apply(1, PC_OP_CALL, 8'h00, 8'hB0, 8'hB0, 0, 0, 0, "call_b0");
      apply(1, PC_OP_CALL, 8'h00, 8'hC0, 8'hC0, 0, 0, 0, "call_c0");
      apply(1, PC_OP_CALL, 8'h00, 8'hD0, 8'hD0, 0, 1, 0, "call_d0_full");
      apply(1, PC_OP_CALL, 8'h00, 8'h40, OVF_CALL_PC, 0, 1, 1, "call_overflow");
      apply(1, PC_OP_RET,  8'h00, 8'h00, 8'hC1, 0, 0, 1, "ret_c1");
      apply(1, PC_OP_RET,  8'h00, 8'h00, 8'hB1, 0, 0, 1, "ret_b1");
      apply(1, PC_OP_RET,  8'h00, 8'h00, 8'hA1, 0, 0, 1, "ret_a1");
      apply(1, PC_OP_RET,  8'h00, 8'h00, 8'h22, 1, 0, 1, "ret_22");
      apply(1, PC_OP_RET,  8'h00, 8'h00, UNF_RET_PC_A, 1, 0, 1, "ret_underflow");
      apply(1, PC_OP_CALL, 8'h00, 8'h30, 8'h30, 0, 0, 1, "call_30");
      apply(0, PC_OP_HOLD, 8'h00, 8'h00, 8'h30, 0, 0, 1, "idle");
      repeat (3) @(posedge clock);

      // Asynchronous reset in the middle of a cycle with a call pending.
      @(posedge clock);
      #1;
      en = 1'b1;
      op = PC_OP_CALL;
      target = 8'h55;
      #3;
      reset = 1'b0;
      #1;
      chk("async_reset", {pc_out, pc_seq, stack_empty, stack_full, err}, pack(8'h00, 1, 0, 0));
      @(posedge clock);
      #1;
      chk("reset_held", {pc_out, pc_seq, stack_empty, stack_full, err}, pack(8'h00, 1, 0, 0));
      en = 1'b0;
      op = PC_OP_HOLD;
      reset = 1'b1;

      apply(1, PC_OP_RET,  8'h00, 8'h00, UNF_RET_PC_B, 1, 0, 1, "ret_empty_after_reset");
      apply(0, PC_OP_HOLD, 8'h00, 8'h00, UNF_RET_PC_B, 1, 0, 1, "final_idle");
      repeat (3) @(posedge clock);

      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_pc_unit
`default_nettype wire
